// File: rtl/mod_reduce.sv
// Limb-serial modular reduction: returns S - M when S >= M, else S, one limb per cycle.
// Optional MOD_SUB_FIXUP_EN adds an in_sub port; negative differences are corrected by adding M.
module mod_reduce #(
    parameter int unsigned LIMB  = 64,
    parameter int unsigned NLIMB = 9
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [514:0] in_sum,
    input  logic [513:0] in_mod,
`ifdef MOD_SUB_FIXUP_EN
    input  logic         in_sub,
`endif
    output logic [513:0] result,
    output logic         done,
    output logic         busy
);

    localparam int unsigned SUM_W = 515;
    localparam int unsigned MOD_W = 514;
    localparam int unsigned W     = LIMB * NLIMB;
    localparam int unsigned LW    = LIMB + 1;
    localparam int unsigned KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINAL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]    s_q;
    logic [W-1:0]    m_q;
    logic [W-1:0]    d_q;
    logic            cy_q;
    logic [KW-1:0]   k_q;
    logic            add_q;

    logic            load;
    logic            step;
    logic            commit;
    logic            busy_d;
    logic            done_d;
    logic            last_limb;

    logic [LIMB-1:0] s_lo;
    logic [LIMB-1:0] m_lo;
    logic [LW-1:0]   limb_res;

    assign last_limb = (k_q == KW'(NLIMB - 1));
    assign s_lo      = s_q[LIMB-1:0];
    assign m_lo      = m_q[LIMB-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step   = 1'b1;
                busy_d = 1'b1;
                if (last_limb) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                commit  = 1'b1;
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One limb of S - M - borrow, or S + M + carry when fixing up a negative difference
    always_comb begin
        if (add_q) begin
            limb_res = {1'b0, s_lo} + {1'b0, m_lo} + LW'(cy_q);
        end else begin
            limb_res = {1'b0, s_lo} - {1'b0, m_lo} - LW'(cy_q);
        end
    end

    // S and M rotate so the original S is back in place for the final select; D fills from the top
    always_ff @(posedge clk) begin
        if (resetn) begin
            s_q    <= '0;
            m_q    <= '0;
            d_q    <= '0;
            cy_q   <= 1'b0;
            k_q    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= done_d;
            busy <= busy_d;
            if (load) begin
                s_q  <= W'(in_sum);
                m_q  <= W'(in_mod);
                cy_q <= 1'b0;
                k_q  <= '0;
            end
            if (step) begin
                s_q  <= {s_lo, s_q[W-1:LIMB]};
                m_q  <= {m_lo, m_q[W-1:LIMB]};
                d_q  <= {limb_res[LIMB-1:0], d_q[W-1:LIMB]};
                cy_q <= limb_res[LIMB];
                k_q  <= k_q + KW'(1);
            end
            if (commit) begin
                result <= (add_q || !cy_q) ? d_q[MOD_W-1:0] : s_q[MOD_W-1:0];
            end
        end
    end

`ifdef MOD_SUB_FIXUP_EN
    // Add mode only for a subtract whose result came out negative
    always_ff @(posedge clk) begin
        if (resetn) begin
            add_q <= 1'b0;
        end else if (load) begin
            add_q <= in_sub & in_sum[SUM_W-1];
        end
    end
`else
    assign add_q = 1'b0;
`endif

endmodule

// File: tb/tb_mod_reduce.sv
// Directed bench for mod_reduce: residues, latency, busy window, reset and start-ignore behaviour.
// Build with MOD_SUB_FIXUP_EN defined to also cover the negative-difference fixup.
module tb_mod_reduce;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [514:0] in_sum;
    logic [513:0] in_mod;
    logic         in_sub;
    logic [513:0] result;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    mod_reduce dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_sum (in_sum),
        .in_mod (in_mod),
`ifdef MOD_SUB_FIXUP_EN
        .in_sub (in_sub),
`endif
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and watch 15 cycles; cycle c is the c-th cycle after the start cycle
    task automatic do_op(input string tag, input logic [514:0] s, input logic [513:0] m,
                         input logic sub, input bit repulse, input logic [513:0] exp);
        int done_cyc   = 0;
        int ndone      = 0;
        int nbusy      = 0;
        int first_busy = 0;
        logic [513:0] res_at_done = '0;
        @(negedge clk);
        in_sum = s;
        in_mod = m;
        in_sub = sub;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        in_sum = ~s;
        in_mod = ~m;
        in_sub = ~sub;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (busy) begin
                nbusy++;
                if (first_busy == 0) first_busy = c;
            end
            if (done) begin
                ndone++;
                done_cyc    = c;
                res_at_done = result;
            end
            if (repulse && c == 3) begin
                start  = 1'b1;
                in_sum = 515'd5;
                in_mod = 514'd7;
            end
            if (repulse && c == 4) start = 1'b0;
        end
        check({tag, ".result"}, 576'(res_at_done), 576'(exp));
        check({tag, ".stable"}, 576'(result), 576'(exp));
        check({tag, ".done_cycle"}, 576'(done_cyc), 576'(11));
        check({tag, ".done_count"}, 576'(ndone), 576'(1));
        check({tag, ".busy_cycles"}, 576'(nbusy), 576'(10));
        check({tag, ".busy_first"}, 576'(first_busy), 576'(2));
    endtask

    initial begin
        logic [514:0] s_big;
        logic [513:0] m_big;
        logic [513:0] e_big;
        logic [514:0] s_neg;
        logic [514:0] t;
        int           nd;
        int           nb;

        resetn = 1'b1;
        start  = 1'b0;
        in_sum = '0;
        in_mod = '0;
        in_sub = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("reset.result", 576'(result), 576'(0));
        check("reset.done", 576'(done), 576'(0));
        check("reset.busy", 576'(busy), 576'(0));

        do_op("lt", 515'd5, 514'd7, 1'b0, 1'b0, 514'd5);
        do_op("eq", 515'd7, 514'd7, 1'b0, 1'b0, 514'd0);
        do_op("gt", 515'd12, 514'd7, 1'b0, 1'b0, 514'd5);

        s_big = '0; s_big[514] = 1'b1; s_big[2] = 1'b1;
        m_big = '0; m_big[513] = 1'b1; m_big[1:0] = 2'b11;
        e_big = '0; e_big[513] = 1'b1; e_big[0] = 1'b1;
        do_op("big", s_big, m_big, 1'b0, 1'b0, e_big);

        // Outside the precondition: still a single subtraction
        do_op("once", 515'd20, 514'd7, 1'b0, 1'b0, 514'd13);
        s_big = '0; s_big[514] = 1'b1; s_big[3:0] = 4'd10;
        do_op("carry", s_big, 514'd7, 1'b0, 1'b0, 514'd3);
        do_op("mzero", 515'd5, 514'd0, 1'b0, 1'b0, 514'd5);

        s_neg = {{514{1'b1}}, 1'b0};
        t     = s_neg - 515'd7;
`ifdef MOD_SUB_FIXUP_EN
        do_op("fix_sub", s_neg, 514'd7, 1'b1, 1'b0, 514'd5);
`endif
        do_op("fix_nosub", s_neg, 514'd7, 1'b0, 1'b0, t[513:0]);

        // Start re-pulsed mid-run with other operands is ignored
        do_op("repulse", 515'd20, 514'd7, 1'b0, 1'b1, 514'd13);

        // Reset during RUN discards the operation
        @(negedge clk);
        in_sum = 515'd12;
        in_mod = 514'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        check("midreset.busy", 576'(busy), 576'(0));
        check("midreset.done", 576'(done), 576'(0));
        check("midreset.result", 576'(result), 576'(0));
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("midreset.no_done", 576'(nd), 576'(0));
        do_op("after_reset", 515'd3, 514'd2, 1'b0, 1'b0, 514'd1);

        // Reset and start in the same cycle: reset wins
        @(negedge clk);
        in_sum = 515'd12;
        in_mod = 514'd7;
        start  = 1'b1;
        resetn = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b0;
        nd = 0;
        nb = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        check("rststart.done", 576'(nd), 576'(0));
        check("rststart.busy", 576'(nb), 576'(0));
        check("rststart.result", 576'(result), 576'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
